// File: rtl/audio_mix_i2s.sv
// audio_mix_i2s: pans PSG channels, adds PCM with saturation, and serializes 16-bit I2S frames.
module audio_mix_i2s #(
  parameter int BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  ch_a,
  input  logic [9:0]  ch_b,
  input  logic [9:0]  ch_c,
  input  logic [15:0] pcm_l,
  input  logic [15:0] pcm_r,
  input  logic        psg_mute,
  output logic        sample_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);
  localparam int DW = $clog2(BCLK_DIV);
  logic [DW-1:0] r_div_cnt;
  logic [4:0]    r_bit_cnt;
  logic [15:0]   r_mix_l, r_mix_r, r_shift_l, r_shift_r;
  logic [11:0]   w_psg_l, w_psg_r;
  logic [15:0]   w_mix_l, w_mix_r;
  logic [4:0]    w_n;
  logic [3:0]    w_idx;
  logic          w_wrap, w_fe;
  function automatic logic [15:0] sat_add(input logic [15:0] pcm, input logic [11:0] psg);
    logic [16:0] s;
    s = {pcm[15], pcm} + {2'b00, psg, 3'b000};
    return (s[16] == s[15]) ? s[15:0] : (s[16] ? 16'h8000 : 16'h7FFF);
  endfunction
  assign w_psg_l = psg_mute ? 12'd0 : {1'b0, ch_a, 1'b0} + {2'b00, ch_b};
  assign w_psg_r = psg_mute ? 12'd0 : {1'b0, ch_c, 1'b0} + {2'b00, ch_b};
  assign w_mix_l = sat_add(pcm_l, w_psg_l);
  assign w_mix_r = sat_add(pcm_r, w_psg_r);
  assign w_wrap  = r_div_cnt == DW'(BCLK_DIV - 1);
  assign w_fe    = w_wrap && i2s_bclk;
  assign w_n     = r_bit_cnt + 5'd1;
  // both halves map slot n to bit (15 - n mod 16)
  assign w_idx   = ~w_n[3:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= 5'd31;
      r_mix_l       <= '0;
      r_mix_r       <= '0;
      r_shift_l     <= '0;
      r_shift_r     <= '0;
      sample_strobe <= 1'b0;
      i2s_bclk      <= 1'b0;
      i2s_lrck      <= 1'b0;
      i2s_sdata     <= 1'b0;
    end else begin
      r_mix_l       <= w_mix_l;
      r_mix_r       <= w_mix_r;
      r_div_cnt     <= w_wrap ? '0 : r_div_cnt + DW'(1);
      sample_strobe <= w_fe && w_n == 5'd0;
      if (w_wrap)
        i2s_bclk <= ~i2s_bclk;
      if (w_fe) begin
        r_bit_cnt <= w_n;
        i2s_lrck  <= w_n >= 5'd15 && w_n != 5'd31;
        if (w_n == 5'd0) begin
          r_shift_l <= r_mix_l;
          r_shift_r <= r_mix_r;
          i2s_sdata <= r_mix_l[15];
        end else
          i2s_sdata <= w_n[4] ? r_shift_r[w_idx] : r_shift_l[w_idx];
      end
    end
  end
endmodule
